instr_mem_loader: RTL and testbench

- Instruction-fetch-side memory for the single-cycle 16-bit core: 64x16 instruction store with an asynchronous read port driven by the core's 6-bit PC.
- Also a byte-stream load port (valid/ready) that fills the store after power-up or on demand.
- Holds the core in reset (core_rst) for the whole load, then releases it so fetch starts at PC 0 with valid contents.

---
 rtl/instr_mem_pkg.sv | 26 ++
 rtl/instr_ram.sv | 26 ++
 rtl/instr_mem_loader.sv | 119 +++++++++++
 tb/tb_instr_mem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and loader state encoding for the instruction-fetch memory.
package instr_mem_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   // Word count used when a load asks for 0 or more words than the store holds
   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV_HI = 2'd1,
      RECV_LO = 2'd2,
      RUN     = 2'd3
   } loader_state_t;

   // A length of 0, or one larger than the store, means "fill the whole store"
   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
      if (len == '0 || len > FULL_LEN) begin
         return FULL_LEN;
      end
      return len;
   endfunction

endpackage

// File: rtl/instr_ram.sv
// Instruction store: synchronous write port, asynchronous read port.
// Contents are never cleared by reset so a program survives a core restart.
module instr_ram
   import instr_mem_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write one word on the rising edge when enabled
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A read of the word being written returns the old value until the edge
   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream loader. Bytes arrive high byte first
// and are assembled into 16-bit words. The core is held in reset for the whole
// load and released one edge after the last word is written, so its first
// fetch from PC 0 sees the final contents.
module instr_mem_loader
   import instr_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [DATA_W-1:0] instr_out,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_len,
   input  logic [7:0]        ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              core_rst,
   output logic              ld_busy,
   output logic              ld_done,
   output logic [ADDR_W:0]   word_cnt
);

   loader_state_t     state_q, state_d;
   logic [7:0]        hi_byte_q, hi_byte_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              core_rst_q, core_rst_d;

   logic              accept;
   logic              we;
   logic [DATA_W-1:0] wdata;

   // Ready depends only on registered state so it never combinationally
   // follows ld_valid
   assign ld_ready  = (state_q == RECV_HI) || (state_q == RECV_LO);
   assign ld_busy   = ld_ready;
   assign ld_done   = (state_q == RUN);
   assign accept    = ld_valid && ld_ready;
   assign core_rst  = core_rst_q;
   assign word_cnt  = word_cnt_q;

   // Next-state, byte assembly and write strobe
   always_comb begin
      state_d    = state_q;
      hi_byte_d  = hi_byte_q;
      wr_addr_d  = wr_addr_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      we         = 1'b0;
      wdata      = {hi_byte_q, ld_data};

      case (state_q)
         IDLE, RUN: begin
            if (ld_start) begin
               state_d    = RECV_HI;
               len_d      = clamp_len(ld_len);
               word_cnt_d = '0;
               wr_addr_d  = '0;
            end
         end
         RECV_HI: begin
            if (accept) begin
               hi_byte_d = ld_data;
               state_d   = RECV_LO;
            end
         end
         RECV_LO: begin
            if (accept) begin
               we         = 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_cnt_d == len_q) begin
                  // Address stays on the last word written; no wrap to 0
                  state_d = RUN;
               end else begin
                  wr_addr_d = wr_addr_q + 1'b1;
                  state_d   = RECV_HI;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Release the core only after a full cycle spent in RUN; any exit from
      // RUN (a new load) reasserts it on the same edge
      core_rst_d = !((state_q == RUN) && (state_d == RUN));
   end

   // State registers with synchronous reset; memory is left untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hi_byte_q  <= '0;
         wr_addr_q  <= '0;
         word_cnt_q <= '0;
         len_q      <= FULL_LEN;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         hi_byte_q  <= hi_byte_d;
         wr_addr_q  <= wr_addr_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         core_rst_q <= core_rst_d;
      end
   end

   instr_ram u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_addr_q),
      .wdata (wdata),
      .raddr (pc_in),
      .rdata (instr_out)
   );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;
   import instr_mem_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] pc_in;
   logic [DATA_W-1:0] instr_out;
   logic              ld_start;
   logic [ADDR_W:0]   ld_len;
   logic [7:0]        ld_data;
   logic              ld_valid;
   logic              ld_ready;
   logic              core_rst;
   logic              ld_busy;
   logic              ld_done;
   logic [ADDR_W:0]   word_cnt;

   int checks = 0;
   int errors = 0;

   instr_mem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .instr_out (instr_out),
      .ld_start  (ld_start),
      .ld_len    (ld_len),
      .ld_data   (ld_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .core_rst  (core_rst),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .word_cnt  (word_cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case something stalls beyond every bounded wait
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse ld_start for one cycle with the given length
   task automatic applyStimulus(input logic [ADDR_W:0] len);
      ld_start = 1'b1;
      ld_len   = len;
      step();
      ld_start = 1'b0;
   endtask

   // Offer one byte and return just after the edge that accepts it
   task automatic sendByte(input logic [7:0] b);
      int n = 0;
      ld_data  = b;
      ld_valid = 1'b1;
      while (!ld_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) checkOutput("ready_timeout", 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
   endtask

   task automatic readWord(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      pc_in = a;
      #1;
      checkOutput(tag, 32'(instr_out), 32'(exp));
   endtask

   // Status outputs that identify the idle/reset condition
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      checkOutput({tag, "_ready"},    32'(ld_ready), 32'd0);
      checkOutput({tag, "_busy"},     32'(ld_busy),  32'd0);
      checkOutput({tag, "_done"},     32'(ld_done),  32'd0);
      checkOutput({tag, "_wcnt"},     32'(word_cnt), 32'd0);
   endtask

   initial begin
      logic [7:0] pat;
      rst      = 1'b1;
      pc_in    = '0;
      ld_start = 1'b0;
      ld_len   = '0;
      ld_data  = '0;
      ld_valid = 1'b0;

      // Reset for two cycles, then idle for ten with no load
      step();
      step();
      checkIdle("rst");
      rst = 1'b0;
      repeat (10) step();
      checkIdle("idle_hold");

      // Three-word load with continuous valid
      applyStimulus(7'd3);
      checkOutput("l1_ready_after_start", 32'(ld_ready), 32'd1);
      checkOutput("l1_busy", 32'(ld_busy), 32'd1);
      sendByte(8'h12); sendByte(8'h34);
      sendByte(8'hAB); sendByte(8'hCD);
      sendByte(8'h00); sendByte(8'hFF);
      checkOutput("l1_wcnt", 32'(word_cnt), 32'd3);
      checkOutput("l1_done", 32'(ld_done), 32'd1);
      checkOutput("l1_busy_end", 32'(ld_busy), 32'd0);
      checkOutput("l1_core_rst_edge1", 32'(core_rst), 32'd1);
      step();
      checkOutput("l1_core_rst_edge2", 32'(core_rst), 32'd0);
      readWord("l1_mem0", 6'd0, 16'h1234);
      readWord("l1_mem1", 6'd1, 16'hABCD);
      readWord("l1_mem2", 6'd2, 16'h00FF);
      step();

      // Same load with gaps between bytes and a long hi/lo gap on word 1
      applyStimulus(7'd3);
      sendByte(8'h12); step();
      sendByte(8'h34); step();
      sendByte(8'hAB);
      for (int i = 0; i < 5; i++) begin
         checkOutput("l2_gap_ready", 32'(ld_ready), 32'd1);
         checkOutput("l2_gap_wcnt", 32'(word_cnt), 32'd1);
         step();
      end
      sendByte(8'hCD); step();
      sendByte(8'h00); step();
      sendByte(8'hFF);
      checkOutput("l2_wcnt", 32'(word_cnt), 32'd3);
      checkOutput("l2_done", 32'(ld_done), 32'd1);
      step();
      readWord("l2_mem0", 6'd0, 16'h1234);
      readWord("l2_mem1", 6'd1, 16'hABCD);
      readWord("l2_mem2", 6'd2, 16'h00FF);
      step();

      // Length 0 fills all 64 words with {addr, ~addr}
      applyStimulus(7'd0);
      for (int a = 0; a < 64; a++) begin
         pat = 8'(a);
         sendByte(pat);
         sendByte(~pat);
      end
      checkOutput("full_wcnt", 32'(word_cnt), 32'd64);
      checkOutput("full_done", 32'(ld_done), 32'd1);
      checkOutput("full_core_rst_edge1", 32'(core_rst), 32'd1);
      step();
      checkOutput("full_core_rst_edge2", 32'(core_rst), 32'd0);
      // Extra bytes offered in RUN must not be accepted
      ld_data  = 8'hEE;
      ld_valid = 1'b1;
      checkOutput("full_run_ready", 32'(ld_ready), 32'd0);
      step();
      step();
      ld_valid = 1'b0;
      checkOutput("full_wcnt_hold", 32'(word_cnt), 32'd64);
      readWord("full_mem63", 6'd63, 16'h3FC0);
      readWord("full_mem0",  6'd0,  16'h00FF);
      readWord("full_mem1",  6'd1,  16'h01FE);
      readWord("full_mem32", 6'd32, 16'h20DF);
      step();

      // Reload from RUN: core goes back into reset on the start edge
      applyStimulus(7'd1);
      checkOutput("rl_core_rst", 32'(core_rst), 32'd1);
      checkOutput("rl_done_clr", 32'(ld_done), 32'd0);
      checkOutput("rl_wcnt_clr", 32'(word_cnt), 32'd0);
      sendByte(8'h5A);
      sendByte(8'h5A);
      checkOutput("rl_wcnt", 32'(word_cnt), 32'd1);
      checkOutput("rl_core_rst_edge1", 32'(core_rst), 32'd1);
      step();
      checkOutput("rl_core_rst_edge2", 32'(core_rst), 32'd0);
      readWord("rl_mem0", 6'd0, 16'h5A5A);
      readWord("rl_mem1", 6'd1, 16'h01FE);
      step();

      // Reset in the middle of a four-word load
      applyStimulus(7'd4);
      sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkIdle("mid_rst");
      readWord("mid_mem0", 6'd0, 16'h1122);
      readWord("mid_mem1", 6'd1, 16'h01FE);
      step();
      applyStimulus(7'd1);
      sendByte(8'h77);
      sendByte(8'h88);
      checkOutput("post_wcnt", 32'(word_cnt), 32'd1);
      checkOutput("post_done", 32'(ld_done), 32'd1);
      readWord("post_mem0", 6'd0, 16'h7788);
      readWord("post_mem1", 6'd1, 16'h01FE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
